// File: rtl/vq_speaker_classifier_pkg.sv
// Shared types and constants for the VQ speaker classifier.
// Includes the FSM state encoding and the per-speaker codebook offset function.
package vq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_WAIT,
    ST_NORM,
    ST_CMP,
    ST_DONE
  } state_t;

  localparam int CB_WORDS_DEF      = 496;
  localparam int REJECT_THRESH_DEF = 22200;

  // Evaluated at elaboration only, so it builds a constant table and no multiplier.
  function automatic int cb_offset(input int spk, input int words);
    return spk * words;
  endfunction

endpackage

// File: rtl/vq_speaker_classifier_seq_divider.sv
// Restoring divider: DIST_W-bit dividend over a FRAME_W-bit divisor, one quotient bit per cycle.
// o_done pulses DIST_W+1 cycles after i_start; the remainder is dropped.
module seq_divider #(
  parameter int DIST_W  = 30,
  parameter int FRAME_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [DIST_W-1:0]  i_dividend,
  input  logic [FRAME_W-1:0] i_divisor,
  output logic               o_done,
  output logic [DIST_W-1:0]  o_quotient
);

  localparam int CNT_W = $clog2(DIST_W + 1);

  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_div;
  logic [FRAME_W-1:0] r_rem;
  logic [DIST_W-1:0]  r_quo;

  logic [FRAME_W:0]   w_shift;
  logic [FRAME_W+1:0] w_diff;
  logic               w_qbit;
  logic               w_unused_diff;

  // The partial remainder stays below the divisor, so the shifted value fits in FRAME_W+1 bits.
  assign w_shift       = {r_rem, r_quo[DIST_W-1]};
  assign w_diff        = {1'b0, w_shift} - {2'b00, r_div};
  assign w_qbit        = ~w_diff[FRAME_W+1];
  assign w_unused_diff = w_diff[FRAME_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= CNT_W'(DIST_W);
        r_div  <= i_divisor;
        r_rem  <= '0;
        r_quo  <= i_dividend;
      end else if (r_busy) begin
        r_rem <= w_qbit ? w_diff[FRAME_W-1:0] : w_shift[FRAME_W-1:0];
        r_quo <= {r_quo[DIST_W-2:0], w_qbit};
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/vq_speaker_classifier.sv
// Sequences the distortion engine over SPK_NUM codebooks and picks the nearest speaker.
// Define VQ_SPK_MARGIN_EN to also reject when the best-vs-second-best gap is below min_margin.
module vq_speaker_classifier
  import vq_pkg::*;
#(
  parameter int SPK_NUM  = 4,
  parameter int SPK_W    = $clog2(SPK_NUM),
  parameter int CB_WORDS = CB_WORDS_DEF,
  parameter int CB_AW    = 11,
  parameter int FRAME_W  = 9,
  parameter int DIST_W   = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_count,
  input  logic [DIST_W-1:0]  reject_thresh,
  input  logic [DIST_W-1:0]  min_margin,
  input  logic               eng_ready,
  output logic               eng_cfg_valid,
  output logic [FRAME_W-1:0] eng_cfg_data,
  output logic               eng_cfg_last,
  input  logic               eng_valid,
  input  logic [DIST_W-1:0]  eng_dist,
  input  logic [CB_AW-1:0]   eng_cb_addr,
  output logic [CB_AW-1:0]   cb_addr,
  output logic               busy,
  output logic               result_valid,
  output logic [SPK_W-1:0]   result_id,
  output logic               result_reject,
  output logic [DIST_W-1:0]  best_dist
);

  state_t             r_state;
  state_t             w_state_next;

  logic [FRAME_W-1:0] r_F;
  logic [DIST_W-1:0]  r_thresh;
  logic [SPK_W-1:0]   r_spk;
  logic [FRAME_W-1:0] r_idx;
  logic [DIST_W-1:0]  r_best;
  logic [SPK_W-1:0]   r_best_id;
  logic               r_reject;

  logic               w_cfg_last;
  logic               w_last_spk;
  logic               w_div_start;
  logic               w_div_done;
  logic [DIST_W-1:0]  w_quot;
  logic               w_better;
  logic [DIST_W-1:0]  w_best_nx;
  logic               w_margin_fail;
  logic               w_reject_nx;
  logic [CB_AW-1:0]   w_off_tbl [2**SPK_W];

  generate
    for (genvar gi = 0; gi < 2**SPK_W; gi++) begin : g_off
      localparam int OFF = (gi < SPK_NUM) ? cb_offset(gi, CB_WORDS) : 0;
      assign w_off_tbl[gi] = OFF[CB_AW-1:0];
    end
  endgenerate

  assign cb_addr = eng_cb_addr + w_off_tbl[r_spk];

  seq_divider #(
    .DIST_W (DIST_W),
    .FRAME_W(FRAME_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_div_start),
    .i_dividend(eng_dist),
    .i_divisor (r_F),
    .o_done    (w_div_done),
    .o_quotient(w_quot)
  );

  assign w_cfg_last = (r_idx == r_F - FRAME_W'(1));
  assign w_last_spk = (r_spk == SPK_W'(SPK_NUM - 1));
  assign w_better   = (w_quot < r_best);
  assign w_best_nx  = w_better ? w_quot : r_best;

`ifdef VQ_SPK_MARGIN_EN
  logic [DIST_W-1:0] r_margin;
  logic [DIST_W-1:0] r_second;
  logic [DIST_W-1:0] w_second_nx;

  assign w_second_nx   = w_better ? r_best : ((w_quot < r_second) ? w_quot : r_second);
  assign w_margin_fail = ((w_second_nx - w_best_nx) < r_margin);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_margin <= '0;
      r_second <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_margin <= min_margin;
      r_second <= '1;
    end else if (r_state == ST_CMP) begin
      r_second <= w_second_nx;
    end
  end
`else
  logic w_unused_margin;
  assign w_unused_margin = ^min_margin;
  assign w_margin_fail   = 1'b0;
`endif

  assign w_reject_nx = (w_best_nx >= r_thresh) || w_margin_fail;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_div_start   = 1'b0;
    eng_cfg_valid = 1'b0;
    eng_cfg_last  = 1'b0;
    busy          = 1'b1;
    result_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = (frame_count == '0) ? ST_DONE : ST_CFG;
      end
      ST_CFG: begin
        eng_cfg_valid = 1'b1;
        eng_cfg_last  = w_cfg_last;
        if (eng_ready && w_cfg_last) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_valid) begin
          w_div_start  = 1'b1;
          w_state_next = ST_NORM;
        end
      end
      ST_NORM: if (w_div_done) w_state_next = ST_CMP;
      ST_CMP:  w_state_next = w_last_spk ? ST_DONE : ST_CFG;
      ST_DONE: begin
        result_valid = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_F       <= '0;
      r_thresh  <= '0;
      r_spk     <= '0;
      r_idx     <= '0;
      r_best    <= '0;
      r_best_id <= '0;
      r_reject  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_F       <= frame_count;
            r_thresh  <= reject_thresh;
            r_spk     <= '0;
            r_idx     <= '0;
            r_best    <= '1;
            r_best_id <= '0;
            r_reject  <= (frame_count == '0);
          end
        end
        ST_CFG: if (eng_ready && !w_cfg_last) r_idx <= r_idx + FRAME_W'(1);
        ST_CMP: begin
          // Strict compare keeps the lower index on ties.
          r_best <= w_best_nx;
          if (w_better) r_best_id <= r_spk;
          if (w_last_spk) r_reject <= w_reject_nx;
          r_spk <= r_spk + SPK_W'(1);
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign eng_cfg_data  = r_idx;
  assign result_id     = r_best_id;
  assign result_reject = r_reject;
  assign best_dist     = r_best;

endmodule

// File: tb/tb_vq_speaker_classifier.sv
// Directed bench for vq_speaker_classifier with a small engine model (fixed 3-cycle result latency).
module tb_vq_speaker_classifier;

  localparam int DW = 30;
  localparam int FW = 9;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] frame_count;
  logic [DW-1:0] reject_thresh;
  logic [DW-1:0] min_margin;
  logic          eng_ready;
  logic          eng_cfg_valid;
  logic [FW-1:0] eng_cfg_data;
  logic          eng_cfg_last;
  logic          eng_valid;
  logic [DW-1:0] eng_dist;
  logic [AW-1:0] eng_cb_addr;
  logic [AW-1:0] cb_addr;
  logic          busy;
  logic          result_valid;
  logic [1:0]    result_id;
  logic          result_reject;
  logic [DW-1:0] best_dist;

  always #5 clk = ~clk;

  vq_speaker_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_count  (frame_count),
    .reject_thresh(reject_thresh),
    .min_margin   (min_margin),
    .eng_ready    (eng_ready),
    .eng_cfg_valid(eng_cfg_valid),
    .eng_cfg_data (eng_cfg_data),
    .eng_cfg_last (eng_cfg_last),
    .eng_valid    (eng_valid),
    .eng_dist     (eng_dist),
    .eng_cb_addr  (eng_cb_addr),
    .cb_addr      (cb_addr),
    .busy         (busy),
    .result_valid (result_valid),
    .result_id    (result_id),
    .result_reject(result_reject),
    .best_dist    (best_dist)
  );

  typedef struct {
    int unsigned f;
    int unsigned d0, d1, d2, d3;
    int unsigned thresh;
    int unsigned margin;
    int unsigned tog;
    int unsigned exp_id;
    int unsigned exp_rej;
    int unsigned exp_best;
    int unsigned exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // engine model state
  int unsigned m_d [4];
  bit          m_tog = 1'b0;
  int          m_clr_req = 0;
  int          m_clr_ack = 0;
  int          m_spk;
  int          m_cnt;
  bit          m_pending;
  int          xfer_n;
  int          xfer_idx [4096];
  bit          xfer_last [4096];
  int unsigned cb_seen [4];
  int unsigned cb_exp [4] = '{2000, 448, 944, 1440};

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    eng_ready   = 1'b0;
    eng_valid   = 1'b0;
    eng_dist    = '0;
    eng_cb_addr = 11'd2000;
    m_spk = 0; m_cnt = 0; m_pending = 1'b0; xfer_n = 0;
    forever begin
      @(negedge clk);
      eng_valid = 1'b0;
      if (m_clr_ack != m_clr_req) begin
        m_clr_ack = m_clr_req;
        m_spk = 0; m_cnt = 0; m_pending = 1'b0; xfer_n = 0;
        for (int s = 0; s < 4; s++) cb_seen[s] = 0;
      end else begin
        if (m_pending) begin
          m_cnt--;
          if (m_cnt == 0) begin
            eng_valid = 1'b1;
            eng_dist  = DW'(m_d[m_spk % 4]);
            m_spk++;
            m_pending = 1'b0;
          end
        end
        eng_ready = m_tog ? ~eng_ready : 1'b1;
        if (eng_cfg_valid && eng_ready) begin
          if (xfer_n < 4096) begin
            xfer_idx[xfer_n]  = int'(eng_cfg_data);
            xfer_last[xfer_n] = eng_cfg_last;
          end
          xfer_n++;
          if (eng_cfg_last) begin
            cb_seen[m_spk % 4] = int'(cb_addr);
            m_pending = 1'b1;
            m_cnt     = 3;
          end
        end
      end
    end
  end

  task automatic setup(input vec_t v);
    m_d[0] = v.d0; m_d[1] = v.d1; m_d[2] = v.d2; m_d[3] = v.d3;
    m_tog         = v.tog[0];
    frame_count   = FW'(v.f);
    reject_thresh = DW'(v.thresh);
    min_margin    = DW'(v.margin);
    m_clr_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input vec_t v, input string tag);
    int lat;
    int errs;
    setup(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!result_valid && lat < 6000) begin
      @(negedge clk);
      lat++;
    end
    if (!result_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no result_valid, expected one within 6000 cycles", tag);
      return;
    end
    check({tag, ".busy"}, busy, 1);
    check({tag, ".id"}, result_id, v.exp_id);
    check({tag, ".reject"}, result_reject, v.exp_rej);
    check({tag, ".best"}, best_dist, v.exp_best);
    if (v.exp_lat != 0) check({tag, ".latency"}, lat, v.exp_lat);
    check({tag, ".xfers"}, xfer_n, 4 * v.f);
    errs = 0;
    for (int i = 0; i < xfer_n && i < 4096; i++) begin
      if (xfer_idx[i] != int'(i % v.f)) errs++;
      if (xfer_last[i] != ((i % v.f) == v.f - 1)) errs++;
    end
    check({tag, ".order"}, errs, 0);
    for (int s = 0; s < 4; s++) check($sformatf("%s.cb%0d", tag, s), cb_seen[s], cb_exp[s]);
    @(negedge clk);
    check({tag, ".valid_fall"}, result_valid, 0);
    check({tag, ".busy_fall"}, busy, 0);
    check({tag, ".id_hold"}, result_id, v.exp_id);
    check({tag, ".best_hold"}, best_dist, v.exp_best);
  endtask

  vec_t vecs [9];
  vec_t vr;
  int   n_rv;
  int   n_cv;
  int   guard;

  initial begin
    //            f    d0          d1          d2          d3          thr    mrg tog id rej best     lat
    vecs[0] = '{100, 900000,     500000,     700000,     2000000,    22200, 0,  0,  1, 0, 5000,    541};
    vecs[1] = '{100, 2300000,    2220000,    2500000,    3000000,    22200, 0,  0,  1, 1, 22200,   541};
    vecs[2] = '{100, 900000,     800000,     300000,     300000,     22200, 0,  0,  2, 0, 3000,    541};
    vecs[3] = '{5,   1000,       2000,       999,        5000,       22200, 0,  1,  2, 0, 199,     0};
    vecs[4] = '{3,   70000,      66599,      80000,      90000,      22200, 0,  0,  1, 0, 22199,   153};
    vecs[5] = '{1,   7,          5,          5,          9,          5,     0,  0,  1, 1, 5,       145};
    vecs[6] = '{511, 1073741823, 1073741823, 1073741823, 1073741822, 22200, 0,  0,  0, 1, 2101256, 2185};
`ifdef VQ_SPK_MARGIN_EN
    vecs[7] = '{100, 500000,     510000,     900000,     900000,     22200, 200, 0, 0, 1, 5000,    541};
`else
    vecs[7] = '{100, 500000,     510000,     900000,     900000,     22200, 200, 0, 0, 0, 5000,    541};
`endif
    vecs[8] = '{100, 500000,     510000,     900000,     900000,     22200, 50,  0, 0, 0, 5000,    541};

    rst = 1'b1; start = 1'b0; frame_count = '0; reject_thresh = '0; min_margin = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.busy", busy, 0);
    check("rst.cfg_valid", eng_cfg_valid, 0);
    check("rst.cfg_last", eng_cfg_last, 0);
    check("rst.cfg_data", eng_cfg_data, 0);
    check("rst.result_valid", result_valid, 0);
    check("rst.id", result_id, 0);
    check("rst.reject", result_reject, 0);
    check("rst.best", best_dist, 0);

    for (int i = 0; i < 9; i++) run(vecs[i], $sformatf("v%0d", i));

    // zero frames: immediate reject; a start during result_valid is dropped
    vr = '{0, 1, 1, 1, 1, 22200, 0, 0, 0, 1, 0, 0};
    setup(vr);
    start = 1'b1;
    @(negedge clk);
    check("f0.valid", result_valid, 1);
    check("f0.busy", busy, 1);
    check("f0.reject", result_reject, 1);
    check("f0.id", result_id, 0);
    check("f0.best", best_dist, 64'h3FFF_FFFF);
    frame_count = FW'(5);
    @(negedge clk);
    start = 1'b0;
    check("f0.ignored_start_busy", busy, 0);
    check("f0.valid_fall", result_valid, 0);
    repeat (3) @(negedge clk);
    check("f0.cfg_valid", eng_cfg_valid, 0);
    check("f0.xfers", xfer_n, 0);
    check("f0.reject_hold", result_reject, 1);

    // reset while speaker 2 is being configured
    vr = '{5, 2000, 1000, 3000, 4000, 22200, 0, 1, 0, 0, 0, 0};
    setup(vr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(m_spk == 2 && eng_cfg_valid) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("abort.reached_spk2", guard < 2000, 1);
    check("abort.best_before", best_dist, 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_clr_req++;
    check("abort.cfg_valid", eng_cfg_valid, 0);
    n_rv = 0;
    n_cv = 0;
    repeat (200) begin
      @(negedge clk);
      if (result_valid) n_rv++;
      if (eng_cfg_valid) n_cv++;
    end
    check("abort.no_result", n_rv, 0);
    check("abort.no_cfg", n_cv, 0);
    check("abort.busy", busy, 0);
    check("abort.id", result_id, 0);
    check("abort.reject", result_reject, 0);
    check("abort.best", best_dist, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
